r_backward_arbiter: RTL
=======================

# r_backward_arbiter

Read-data return arbiter that merges N packed R-channel streams from downstream slave ports into one packed 79-bit R stream toward the master side. Its output feeds the R-channel field separater directly. Grants are round-robin and held for a whole burst: the lock releases only on the RLAST beat, so beats from different bursts never interleave. There is no per-beat ID interleaving.

## Interface
- N_SRC, 4, number of R sources; legal range 2..8
- ACLK  in  1  clock; all state changes on rising edge
- ARESET  in  1  reset; asynchronous, active-high
- S_DATA  in  N_SRC*79  packed source payloads; source i occupies [i*79+78 : i*79], each packed {RID[7:0],RDATA[63:0],RRESP[1:0],RUSER[3:0],RLAST}
- S_VALID  in  N_SRC  per-source valid
- S_READY  out  N_SRC  per-source ready; at most one bit high
- M_DATA  out  79  merged payload, same packing
- M_VALID  out  1  merged valid
- M_READY  in  1  downstream ready
- GRANT  out  N_SRC  one-hot current owner; 0 when no source is selected
- BUSY  out  1  high while in LOCK

## Operation
- State machine has two states:
  - IDLE: no owner is held.
  - LOCK: owner register OWN is valid.
- Round-robin pointer PTR (clog2(N_SRC) bits) gives the highest-priority index.
  - Search order is PTR, PTR+1, …, N_SRC-1, 0, …, PTR-1.
- Behaviour in IDLE:
  - The winner is the first asserted S_VALID in search order, chosen combinationally.
  - The winner is routed to M_* in the same cycle.
  - S_READY[winner] = M_READY.
- Transitions out of IDLE (winner exists):
  - Handshake with RLAST=1: stay in IDLE, PTR ← winner+1.
  - Any other case, including M_READY=0: go to LOCK with OWN ← winner. M_VALID must not drop or switch source before its handshake completes.
- Behaviour in LOCK:
  - Only OWN is routed. M_VALID = S_VALID[OWN]; all other S_READY are 0.
  - If OWN drops S_VALID between beats, the lock is kept and M_VALID=0.
  - Handshake with RLAST=1 on OWN: go to IDLE, PTR ← OWN+1.
- PTR wraps from N_SRC-1 to 0.
- When no source is selected, M_DATA holds 0.
- Reset values: state=IDLE, PTR=0, OWN=0, S_READY=0, M_VALID=0, M_DATA=0, GRANT=0, BUSY=0.

## Timing
- Latency without the macro: 0 cycles. The source-to-M_* path and the M_READY-to-S_READY path are both combinational.
- Back-to-back bursts have no bubble. The cycle after an RLAST handshake, IDLE arbitration presents the next winner.
- A single-beat burst (RLAST on its first beat) completes in 1 cycle and never enters LOCK.
- Simultaneous valids: the lowest index at or after PTR wins. PTR changes only when a burst completes.
- Reset asserted mid-burst clears all state immediately. That burst's remaining beats arbitrate fresh once reset is deasserted.
- Throughput: 1 beat per cycle while M_READY=1 and the owner is valid.

## Configuration
- RBA_OUTPUT_REG_EN defined:
  - A 2-entry skid buffer sits between the arbiter core and M_*.
  - M_DATA and M_VALID are register outputs; latency is 1 cycle.
  - Owner S_READY = buffer-not-full, registered, with no combinational path from M_READY.
  - Full throughput is kept. The lock releases when RLAST is accepted into the buffer.
- RBA_OUTPUT_REG_EN undefined: pure combinational pass-through, as described above.

## Structure
- Shared package axi4bus_pkg holds:
  - R_PAYLOAD_W=79.
  - Field offsets: RLAST bit 0; RUSER [4:1]; RRESP [6:5]; RDATA [70:7]; RID [78:71].
  - State enum {IDLE, LOCK}.
- Sub-module r_skid_buffer (79-bit, 2-entry valid/ready buffer) is instantiated only under RBA_OUTPUT_REG_EN.
- The round-robin picker stays inline.

## Test plan
- Reset then idle: all S_VALID=0 → M_VALID=0, GRANT=0, S_READY=0; M_DATA=0 after async ARESET pulse without clock.
- Contention: S_VALID=4'b1111, each source sends a 1-beat burst, M_READY=1 → grant order 0,1,2,3,0, one per cycle.
- Burst lock: src1 sends a 4-beat burst while src0 is valid throughout → beats 1..4 of src1 contiguous (RLAST on the 4th); src0 granted next cycle; S_READY[0]=0 during the burst.
- Backpressure: winner src2, M_READY=0 for 3 cycles, src0 asserts valid in cycle 2 → M_DATA stays src2's first beat, GRANT=4'b0100 throughout.
- Owner gap: src3 mid-burst drops S_VALID for 2 cycles while src0 is valid → M_VALID=0, GRANT stays src3, src0 blocked until src3's RLAST.
- Reset mid-burst: ARESET asserted after 2 of 4 beats → state IDLE, PTR=0; after release, lowest-index valid source granted.

Source files
------------

// File: rtl/axi4bus_pkg.sv
// Shared AXI4 R-channel definitions: packed payload layout, field offsets and arbiter states.
package axi4bus_pkg;

  localparam int R_PAYLOAD_W = 79;

  localparam int RLAST_BIT = 0;
  localparam int RUSER_LSB = 1;
  localparam int RUSER_MSB = 4;
  localparam int RRESP_LSB = 5;
  localparam int RRESP_MSB = 6;
  localparam int RDATA_LSB = 7;
  localparam int RDATA_MSB = 70;
  localparam int RID_LSB   = 71;
  localparam int RID_MSB   = 78;

  typedef enum logic {IDLE, LOCK} rba_state_e;

  // Round-robin successor with wrap from n-1 back to 0 (n need not be a power of two).
  function automatic int rr_next(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/r_skid_buffer.sv
// Two-entry valid/ready buffer; in_ready and out_valid come straight from the occupancy register.
module r_skid_buffer #(
  parameter int DATA_W = 79
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  logic [DATA_W-1:0] mem_p0 [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        cnt;
  logic              push;
  logic              pop;

  assign in_ready  = (cnt != 2'd2);
  assign out_valid = (cnt != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_data  = out_valid ? mem_p0[rd_ptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone qualifies it.
  always_ff @(posedge clk) begin
    if (push) mem_p0[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/r_backward_arbiter.sv
// Burst-locked round-robin merge of N_SRC R streams into one.
// Define RBA_OUTPUT_REG_EN to register M_* through a 2-entry skid buffer (1-cycle latency).
module r_backward_arbiter
  import axi4bus_pkg::*;
#(
  parameter int N_SRC = 4
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  input  logic [N_SRC*R_PAYLOAD_W-1:0] S_DATA,
  input  logic [N_SRC-1:0]             S_VALID,
  output logic [N_SRC-1:0]             S_READY,
  output logic [R_PAYLOAD_W-1:0]       M_DATA,
  output logic                         M_VALID,
  input  logic                         M_READY,
  output logic [N_SRC-1:0]             GRANT,
  output logic                         BUSY
);

  localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  rba_state_e             state;
  logic [PTR_W-1:0]       ptr;
  logic [PTR_W-1:0]       own;

  logic                   win_found;
  logic [PTR_W-1:0]       win_idx;
  logic                   sel_on;
  logic [PTR_W-1:0]       sel_idx;
  logic [PTR_W-1:0]       nxt_ptr;
  logic [R_PAYLOAD_W-1:0] core_data;
  logic                   core_valid;
  logic                   core_ready;
  logic                   core_hs;
  logic                   core_last;

  // Scan from the far end so the earliest index in search order overwrites the rest.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (S_VALID[(int'(ptr) + k) % N_SRC]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'((int'(ptr) + k) % N_SRC);
      end
    end
  end

  assign sel_on     = (state == LOCK) | win_found;
  assign sel_idx    = (state == LOCK) ? own : win_idx;
  assign core_valid = sel_on & S_VALID[sel_idx];
  assign core_data  = sel_on ? S_DATA[int'(sel_idx)*R_PAYLOAD_W +: R_PAYLOAD_W] : '0;
  assign core_hs    = core_valid & core_ready;
  assign core_last  = core_data[RLAST_BIT];
  assign nxt_ptr    = PTR_W'(rr_next(int'(sel_idx), N_SRC));
  assign BUSY       = (state == LOCK);

  always_comb begin
    GRANT   = '0;
    S_READY = '0;
    if (sel_on) begin
      GRANT[sel_idx]   = 1'b1;
      S_READY[sel_idx] = core_ready;
    end
  end

  // Any winner not retired by an RLAST handshake this cycle is held until it is.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state <= IDLE;
      ptr   <= '0;
      own   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            if (core_hs && core_last) begin
              ptr <= nxt_ptr;
            end else begin
              state <= LOCK;
              own   <= win_idx;
            end
          end
        end
        LOCK: begin
          if (core_hs && core_last) begin
            state <= IDLE;
            ptr   <= nxt_ptr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RBA_OUTPUT_REG_EN
  r_skid_buffer #(
    .DATA_W(R_PAYLOAD_W)
  ) u_skid (
    .clk      (ACLK),
    .rst      (ARESET),
    .in_data  (core_data),
    .in_valid (core_valid),
    .in_ready (core_ready),
    .out_data (M_DATA),
    .out_valid(M_VALID),
    .out_ready(M_READY)
  );
`else
  assign core_ready = M_READY;
  assign M_DATA     = core_data;
  assign M_VALID    = core_valid;
`endif

endmodule
